hex_display_scan: RTL
=====================

Name: hex_display_scan

Overview:
- Downstream consumer of the 4:1 16-bit operand multiplexer.
- Takes the selected 16-bit word and shows it as four hex digits on a time-multiplexed common-anode 7-segment display.
- Captures a new word on a load strobe and commits it to the display only at a frame boundary, so digits never tear mid-scan.
- Contains a refresh prescaler, a digit scan counter, a hold/display register pair and a registered hex decoder.

Parameters:
- REFRESH_DIV, 100000: clock cycles each digit stays lit. Legal range is 2 to 2^24-1; the prescaler is 24 bits wide.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- data_i  input  16  word from mux output; nibble [3:0] is the rightmost digit
- load_i  input  1  capture strobe; data_i sampled on the rising edge while high
- en_i  input  1  scan enable; low blanks the display
- an_o  output  4  anode enables, active-low; an_o[0] is the rightmost digit
- seg_o  output  7  segments, active-low, {g,f,e,d,c,b,a}
- tick_o  output  1  one-cycle pulse at every digit advance

Behaviour:
- Reset is asynchronous and immediate, including mid-scan. Reset values:
  - hold_q = 0, disp_q = 0, cnt_q = 0, digit_q = 0
  - an_o = 4'b1111, seg_o = 7'h7F, tick_o = 0
- Hold register: hold_q <= data_i on any edge with load_i = 1, independent of en_i.
- Prescaler, while en_i = 1:
  - If cnt_q == REFRESH_DIV-1: cnt_q <= 0, digit_q <= digit_q+1 (mod 4, 3 wraps to 0), tick_o <= 1.
  - Otherwise: cnt_q <= cnt_q+1, tick_o <= 0.
- Frame boundary is a digit advance out of digit 3. On that edge:
  - disp_q <= data_i if load_i = 1 in the same cycle (forwarding);
  - otherwise disp_q <= hold_q.
  - A word therefore reaches the display within one frame (4*REFRESH_DIV cycles) plus 1 cycle.
- Outputs are registered from the current digit_q/disp_q, with one cycle of lag:
  - an_o <= ~(4'b0001 << digit_q)
  - seg_o <= hex decode of disp_q[4*digit_q +: 4]
- Hex decode (active-low values):
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78
  - 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E
- en_i = 0:
  - cnt_q and digit_q are cleared to 0; tick_o <= 0.
  - an_o <= 4'b1111 and seg_o <= 7'h7F on the next edge.
  - disp_q is not updated; hold_q still loads.
  - When en_i returns, the scan restarts at digit 0 with a full REFRESH_DIV dwell.
  - disp_q is updated at the first frame boundary after re-enable, so the display shows the pre-disable word until then.
- No FSM beyond the 2-bit scan counter. Exactly one anode is low at any time while enabled.

Optional Feature:
- Macro: HEX_DISPLAY_LZB_EN (leading-zero blanking).
- Defined: any digit position above the most significant non-zero nibble of disp_q keeps its anode high during its slot. Timing and tick_o are unchanged. Digit 0 is always lit, so disp_q = 0 shows a single "0".
- Undefined: all four digits are always lit, leading zeros included.

Test Plan (REFRESH_DIV = 4):
- Reset, then en_i = 1 with no load -> an_o cycles 1110, 1101, 1011, 0111, each for 4 cycles, 1 cycle after the digit advance; seg_o = 40 throughout; tick_o pulses every 4 cycles.
- load_i pulse with data_i = 16'h1A2F mid-frame -> display stays 0000 until the frame boundary. Next frame shows seg_o: digit0 = 0E, digit1 = 24, digit2 = 08, digit3 = 79.
- load_i = 1 with data_i = 16'hBEEF exactly on the digit-3-to-0 edge -> the very next frame shows BEEF (forwarding). A later load without a boundary changes nothing visible until the following boundary.
- en_i dropped to 0 mid-frame -> next cycle an_o = 1111, seg_o = 7F, tick_o = 0. Re-enable -> digit 0 shown first, with a full 4-cycle dwell.
- rst_n asserted asynchronously mid-digit (between edges) -> an_o = 1111, seg_o = 7F, tick_o = 0 immediately. After release, the display shows 0000 from digit 0.
- With HEX_DISPLAY_LZB_EN and disp = 16'h0030 -> anodes 2 and 3 never go low; digit1 seg_o = 30, digit0 seg_o = 40. Without the macro, all four anodes scan.

Source files
------------

// File: rtl/hex_display_scan.sv
// rtl/hex_display_scan.sv - four-digit multiplexed hex display with frame-aligned commit
// Optional leading-zero blanking enabled by defining HEX_DISPLAY_LZB_EN.
module hex_display_scan #(
    parameter int unsigned REFRESH_DIV = 100000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] data_i,
    input  logic        load_i,
    input  logic        en_i,
    output logic [3:0]  an_o,
    output logic [6:0]  seg_o,
    output logic        tick_o
);

    localparam logic [23:0] LAST_CNT = 24'(REFRESH_DIV - 1);

    logic [15:0] hold_q;
    logic [15:0] disp_q;
    logic [23:0] cnt_q;
    logic [1:0]  digit_q;
    logic [3:0]  nibble;
    logic [6:0]  seg_d;
    logic [3:0]  an_d;
    logic        wrap;

    assign wrap   = (cnt_q == LAST_CNT);
    assign nibble = disp_q[{digit_q, 2'b00} +: 4];

    always_comb begin
        seg_d = 7'h7F;
        case (nibble)
            4'h0: seg_d = 7'h40;
            4'h1: seg_d = 7'h79;
            4'h2: seg_d = 7'h24;
            4'h3: seg_d = 7'h30;
            4'h4: seg_d = 7'h19;
            4'h5: seg_d = 7'h12;
            4'h6: seg_d = 7'h02;
            4'h7: seg_d = 7'h78;
            4'h8: seg_d = 7'h00;
            4'h9: seg_d = 7'h10;
            4'hA: seg_d = 7'h08;
            4'hB: seg_d = 7'h03;
            4'hC: seg_d = 7'h46;
            4'hD: seg_d = 7'h21;
            4'hE: seg_d = 7'h06;
            4'hF: seg_d = 7'h0E;
            default: seg_d = 7'h7F;
        endcase
    end

`ifdef HEX_DISPLAY_LZB_EN
    logic [1:0] msd;

    // Index of the most significant non-zero nibble; digit 0 is always lit.
    always_comb begin
        msd = 2'd0;
        if (disp_q[15:12] != 4'h0)     msd = 2'd3;
        else if (disp_q[11:8] != 4'h0) msd = 2'd2;
        else if (disp_q[7:4] != 4'h0)  msd = 2'd1;
    end

    always_comb begin
        an_d = ~(4'b0001 << digit_q);
        if (digit_q > msd) an_d = 4'b1111;
    end
`else
    always_comb begin
        an_d = ~(4'b0001 << digit_q);
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_q  <= 16'h0000;
            disp_q  <= 16'h0000;
            cnt_q   <= 24'd0;
            digit_q <= 2'd0;
            an_o    <= 4'b1111;
            seg_o   <= 7'h7F;
            tick_o  <= 1'b0;
        end else begin
            if (load_i) hold_q <= data_i;
            if (en_i) begin
                an_o  <= an_d;
                seg_o <= seg_d;
                if (wrap) begin
                    cnt_q   <= 24'd0;
                    digit_q <= digit_q + 2'd1;
                    tick_o  <= 1'b1;
                    // Commit only when leaving the last digit so a frame never mixes two words.
                    if (digit_q == 2'd3) disp_q <= load_i ? data_i : hold_q;
                end else begin
                    cnt_q  <= cnt_q + 24'd1;
                    tick_o <= 1'b0;
                end
            end else begin
                cnt_q   <= 24'd0;
                digit_q <= 2'd0;
                tick_o  <= 1'b0;
                an_o    <= 4'b1111;
                seg_o   <= 7'h7F;
            end
        end
    end

endmodule
